// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-command bundle around mem_port_arbiter.
// The arbiter attaches through the slave modport; requesters and the memory unit attach through master.
interface mem_port_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0][1:0]   req_mode;
  logic [NREQ-1:0][31:0]  req_address;
  logic [NREQ-1:0][31:0]  req_offset;
  logic [NREQ-1:0][31:0]  req_data;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        ack;
  logic [31:0]            rdata;
  logic                   mem_valid;
  logic [1:0]             mem_mode;
  logic [31:0]            mem_address;
  logic [31:0]            mem_offset;
  logic [31:0]            mem_data;
  logic [31:0]            mem_data_out;

  modport slave (
    input  req, req_mode, req_address, req_offset, req_data, mem_data_out,
    output gnt, ack, rdata, mem_valid, mem_mode, mem_address, mem_offset, mem_data
  );

  modport master (
    output req, req_mode, req_address, req_offset, req_data, mem_data_out,
    input  gnt, ack, rdata, mem_valid, mem_mode, mem_address, mem_offset, mem_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter serialising whole memory-port operations (IDLE/ISSUE/WAIT/DONE).
// Define MEM_ARB_FIXED_PRIORITY_EN for lowest-index-wins priority instead of round-robin.
module mem_port_arbiter #(
  parameter int NREQ    = 4,
  parameter int LATENCY = 1
) (
  input logic               clk_i,
  input logic               init_n_i,
  mem_port_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [IW-1:0]   win_q, win_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            mem_valid_q, mem_valid_d;
  logic [1:0]      mem_mode_q, mem_mode_d;
  logic [31:0]     mem_address_q, mem_address_d;
  logic [31:0]     mem_offset_q, mem_offset_d;
  logic [31:0]     mem_data_q, mem_data_d;
  logic [IW-1:0]   pick_s;
  logic            pick_vld_s;

`ifdef MEM_ARB_FIXED_PRIORITY_EN
  // Winner select: lowest set index; scanning downward leaves the lowest one standing.
  always_comb begin
    pick_s     = {IW{1'b0}};
    pick_vld_s = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req[k]) begin
        pick_s     = IW'(k);
        pick_vld_s = 1'b1;
      end else begin
        pick_s     = pick_s;
      end
    end
  end
`else
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW:0]   idx_s;

  // Winner select: first set bit at or after rr_ptr with wrap; downward scan keeps the nearest.
  always_comb begin
    pick_s     = {IW{1'b0}};
    pick_vld_s = 1'b0;
    idx_s      = {(IW+1){1'b0}};
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx_s = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (idx_s >= (IW+1)'(NREQ)) begin
        idx_s = idx_s - (IW+1)'(NREQ);
      end else begin
        idx_s = idx_s;
      end
      if (bus.req[idx_s[IW-1:0]]) begin
        pick_s     = idx_s[IW-1:0];
        pick_vld_s = 1'b1;
      end else begin
        pick_s     = pick_s;
      end
    end
  end
`endif

  // Next-state and registered-output computation for the operation sequencer.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    ack_d         = {NREQ{1'b0}};
    win_d         = win_q;
    cnt_d         = cnt_q;
    rdata_d       = rdata_q;
    mem_valid_d   = 1'b0;
    mem_mode_d    = 2'b00;
    mem_address_d = 32'd0;
    mem_offset_d  = 32'd0;
    mem_data_d    = 32'd0;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
    rr_ptr_d      = rr_ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_vld_s) begin
          // Fields are held stable by the requester, so capturing them here equals ISSUE-cycle values.
          state_d       = S_ISSUE;
          win_d         = pick_s;
          gnt_d         = NREQ'(1) << pick_s;
          mem_valid_d   = 1'b1;
          mem_mode_d    = bus.req_mode[pick_s];
          mem_address_d = bus.req_address[pick_s];
          mem_offset_d  = bus.req_offset[pick_s];
          mem_data_d    = bus.req_data[pick_s];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
`ifndef MEM_ARB_FIXED_PRIORITY_EN
        rr_ptr_d = (win_q == IW'(NREQ - 1)) ? {IW{1'b0}} : win_q + IW'(1);
`endif
        if (LATENCY == 0) begin
          state_d = S_DONE;
          ack_d   = gnt_q;
          rdata_d = bus.mem_data_out;
        end else begin
          state_d = S_WAIT;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          ack_d   = gnt_q;
          rdata_d = bus.mem_data_out;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = {NREQ{1'b0}};
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = {NREQ{1'b0}};
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge init_n_i) begin
    if (!init_n_i) begin
      state_q       <= S_IDLE;
      gnt_q         <= {NREQ{1'b0}};
      ack_q         <= {NREQ{1'b0}};
      win_q         <= {IW{1'b0}};
      cnt_q         <= 4'd0;
      rdata_q       <= 32'd0;
      mem_valid_q   <= 1'b0;
      mem_mode_q    <= 2'b00;
      mem_address_q <= 32'd0;
      mem_offset_q  <= 32'd0;
      mem_data_q    <= 32'd0;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
      rr_ptr_q      <= {IW{1'b0}};
`endif
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      ack_q         <= ack_d;
      win_q         <= win_d;
      cnt_q         <= cnt_d;
      rdata_q       <= rdata_d;
      mem_valid_q   <= mem_valid_d;
      mem_mode_q    <= mem_mode_d;
      mem_address_q <= mem_address_d;
      mem_offset_q  <= mem_offset_d;
      mem_data_q    <= mem_data_d;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
      rr_ptr_q      <= rr_ptr_d;
`endif
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.ack         = ack_q;
  assign bus.rdata       = rdata_q;
  assign bus.mem_valid   = mem_valid_q;
  assign bus.mem_mode    = mem_mode_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_offset  = mem_offset_q;
  assign bus.mem_data    = mem_data_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random-stimulus bench for mem_port_arbiter: two lanes (LATENCY 1 and 0) against a timeline reference model.
module tb_mem_port_arbiter;
  localparam int NREQ = 4;

  logic clk    = 1'b0;
  logic init_n = 1'b0;
  int   cyc    = 0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Expected winner from the arbitration rule: scan requester ids starting at the pointer.
  function automatic int exp_winner(input logic [NREQ-1:0] r, input int p);
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    for (int k = 0; k < NREQ; k++) if (r[k]) return k;
`else
    for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
`endif
    return 0;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 1 : 0;

    mem_port_arbiter_if #(.NREQ(NREQ)) bus ();

    mem_port_arbiter #(.NREQ(NREQ), .LATENCY(LAT)) dut (
      .clk_i    (clk),
      .init_n_i (init_n),
      .bus      (bus)
    );

    logic [31:0]     memhist [0:63];
    int              ptr, t_issue, win, rel;
    bit              busy, post_rst;
    logic [NREQ-1:0] exp_gnt, exp_ack;
    logic            exp_mv;
    logic [1:0]      e_mode, x_mode;
    logic [31:0]     e_addr, e_off, e_data, x_addr, x_off, x_data, rdata_exp;

    // Per-cycle: check outputs against the model, then act as requesters and memory.
    always @(negedge clk) begin
      if (!init_n) begin
        bus.req          = '0;
        bus.req_mode     = '0;
        bus.req_address  = '0;
        bus.req_offset   = '0;
        bus.req_data     = '0;
        bus.mem_data_out = 32'd0;
        busy      = 1'b0;
        ptr       = 0;
        rdata_exp = 32'd0;
        post_rst  = 1'b1;
      end else begin
        rel = cyc - t_issue;
        if (busy && rel > LAT + 1) busy = 1'b0;
        exp_gnt = '0; exp_ack = '0; exp_mv = 1'b0;
        x_mode = 2'b00; x_addr = 32'd0; x_off = 32'd0; x_data = 32'd0;
        if (busy) begin
          exp_gnt = NREQ'(1) << win;
          if (rel == 0) begin
            exp_mv = 1'b1; x_mode = e_mode; x_addr = e_addr; x_off = e_off; x_data = e_data;
          end
          if (rel == LAT + 1) begin
            exp_ack   = exp_gnt;
            rdata_exp = memhist[(t_issue + LAT) % 64];
          end
        end
        check_eq($sformatf("L%0d_gnt", LAT),       32'(bus.gnt),       32'(exp_gnt));
        check_eq($sformatf("L%0d_ack", LAT),       32'(bus.ack),       32'(exp_ack));
        check_eq($sformatf("L%0d_rdata", LAT),     bus.rdata,          rdata_exp);
        check_eq($sformatf("L%0d_mem_valid", LAT), 32'(bus.mem_valid), 32'(exp_mv));
        check_eq($sformatf("L%0d_mem_mode", LAT),  32'(bus.mem_mode),  32'(x_mode));
        check_eq($sformatf("L%0d_mem_address", LAT), bus.mem_address,  x_addr);
        check_eq($sformatf("L%0d_mem_offset", LAT),  bus.mem_offset,   x_off);
        check_eq($sformatf("L%0d_mem_data", LAT),    bus.mem_data,     x_data);

        if (post_rst) begin
          bus.req            = NREQ'(2);
          bus.req_mode[1]    = 2'b00;
          bus.req_address[1] = 32'd9;
          bus.req_offset[1]  = 32'd4;
          bus.req_data[1]    = 32'd0;
          post_rst = 1'b0;
        end else begin
          for (int i = 0; i < NREQ; i++) begin
            if (exp_ack[i]) begin
              bus.req[i] = 1'b0;
            end else if (busy && i == win) begin
              if (rel >= 1 && rel <= LAT && $urandom_range(0, 5) == 0) bus.req[i] = 1'b0;
            end else if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
              bus.req[i]         = 1'b1;
              bus.req_mode[i]    = 2'($urandom);
              bus.req_address[i] = $urandom;
              bus.req_offset[i]  = $urandom;
              bus.req_data[i]    = $urandom;
            end
          end
        end
        bus.mem_data_out  = $urandom;
        memhist[cyc % 64] = bus.mem_data_out;

        if (!busy && bus.req != '0) begin
          win     = exp_winner(bus.req, ptr);
          busy    = 1'b1;
          t_issue = cyc + 1;
          e_mode  = bus.req_mode[win];
          e_addr  = bus.req_address[win];
          e_off   = bus.req_offset[win];
          e_data  = bus.req_data[win];
          ptr     = (win + 1) % NREQ;
        end
      end
    end
  end

  initial begin : main
    int n;
    init_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 init_n = 1'b1;
    repeat (800) @(negedge clk);

    // Reset while the LATENCY=1 lane sits in WAIT (granted, no strobe, no ack).
    n = 0;
    while (!(lane[0].bus.gnt != '0 && !lane[0].bus.mem_valid && lane[0].bus.ack == '0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("wait_state_reached", 32'(n < 200), 32'd1);
    #2 init_n = 1'b0;
    #1;
    check_eq("rst_L1_gnt",   32'(lane[0].bus.gnt),       32'd0);
    check_eq("rst_L1_ack",   32'(lane[0].bus.ack),       32'd0);
    check_eq("rst_L1_rdata", lane[0].bus.rdata,          32'd0);
    check_eq("rst_L1_valid", 32'(lane[0].bus.mem_valid), 32'd0);
    check_eq("rst_L1_cmd",   32'(lane[0].bus.mem_mode) | lane[0].bus.mem_address
                               | lane[0].bus.mem_offset | lane[0].bus.mem_data, 32'd0);
    check_eq("rst_L0_gnt",   32'(lane[1].bus.gnt),       32'd0);
    check_eq("rst_L0_rdata", lane[1].bus.rdata,          32'd0);
    check_eq("rst_L0_valid", 32'(lane[1].bus.mem_valid), 32'd0);
    repeat (2) @(negedge clk);
    #2 init_n = 1'b1;

    // First request after reset is req=0010 alone; it must be granted at ISSUE.
    repeat (2) @(negedge clk);
    #1;
    check_eq("post_rst_gnt", 32'(lane[0].bus.gnt), 32'h2);
    check_eq("post_rst_addr", lane[0].bus.mem_address, 32'd9);

    repeat (1500) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single memory-unit command port between up to NREQ requesters: the instruction-fetch path, the instruction FSMs (index, amend, alloc, abandon) and the console/copy units. It sits between those requesters and the memory unit's `mem_in_bus_t` fields. It serialises whole operations with a req/ack handshake and returns captured read data to the winning requester.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `LATENCY`, 1: memory read-data delay in cycles after the issue cycle, 0..15.

- `clk`  in  1  system clock.
- `init_n`  in  1  asynchronous active-low reset.
- `req`  in  NREQ  per-requester operation request, level.
- `req_mode`  in  2*NREQ  per-requester mode: 00 read, 01 write, 10 alloc, 11 free.
- `req_address`  in  32*NREQ  per-requester array identifier.
- `req_offset`  in  32*NREQ  per-requester offset, or allocation size.
- `req_data`  in  32*NREQ  per-requester write data.
- `gnt`  out  NREQ  one-hot owner of the port; all-zero when idle.
- `ack`  out  NREQ  one-cycle completion pulse to the owner.
- `rdata`  out  32  data captured from memory at completion.
- `mem_valid`  out  1  command strobe to the memory unit.
- `mem_mode`, `mem_address`, `mem_offset`, `mem_data`  out  2/32/32/32  muxed command to the memory unit.
- `mem_data_out`  in  32  memory read data.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any `req` bit is set, pick a winner. The winner is the first set bit at or after `rr_ptr`, searching upward with wrap.
  - Register the winner into `gnt` and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (1 cycle):
  - `mem_valid`=1.
  - `mem_*` driven from the winner's fields, which are sampled this cycle.
  - `rr_ptr` ← (winner+1) mod NREQ.
  - Next state is WAIT, or DONE if LATENCY=0.
- WAIT: counter runs LATENCY cycles, then the block goes to DONE. `mem_valid`=0.
- DONE (1 cycle):
  - `ack[winner]`=1.
  - `rdata` ← `mem_data_out`, registered at entry to DONE and held until the next DONE.
  - Next state is IDLE; `gnt` clears on leaving DONE.
- Requester rules:
  - Hold `req` and the field values stable from assertion through ISSUE.
  - Deassert `req` at the edge ending the DONE cycle.
  - A `req` still high in IDLE is treated as a new request.
- Dropping `req` after ISSUE does not abort the operation; `ack` still pulses.
- `mem_*` outputs are zero whenever `mem_valid`=0.
- Write and free operations complete the same way; `rdata` is still updated but carries no meaning.
- Non-winning requesters wait; no `ack` is lost and no request is starved, since each one waits at most NREQ−1 operations.

## Timing
- Reset values (asynchronous, while `init_n`=0):
  - State IDLE, `rr_ptr`=0, WAIT counter 0.
  - `gnt`=0, `ack`=0, `rdata`=0, `mem_valid`=0, all `mem_*`=0.
- Reset mid-operation aborts immediately with no `ack`. The memory unit may have seen the ISSUE strobe.
- Request latency: `req` high in IDLE cycle t gives ISSUE at t+1, DONE/`ack` at t+2+LATENCY, and IDLE at t+3+LATENCY.
- Throughput: one operation per LATENCY+3 cycles.
- `gnt` is high from ISSUE through DONE inclusive.
- Simultaneous requests are resolved only in IDLE. Requests arriving during ISSUE/WAIT/DONE wait for the next IDLE.
- `rr_ptr` wraps from NREQ−1 to 0.
- LATENCY=0: ISSUE goes directly to DONE, and `mem_data_out` is sampled at the end of ISSUE.

## Configuration
- `MEM_ARB_FIXED_PRIORITY_EN`
  - Defined: winner is the lowest-index set `req`; `rr_ptr` is not implemented, and higher indices may starve.
  - Undefined: round-robin as above.

## Test plan
- **Single request:** NREQ=4, LATENCY=1; `req`=0001, read at address 5, offset 3; memory returns 0xDEADBEEF.
  - `mem_valid` high at t+1 with `mem_address`=5 and `mem_offset`=3.
  - `ack`=0001 at t+3 with `rdata`=0xDEADBEEF.
  - `gnt` is 0 at t+4.
- **Round-robin:** `req`=1111 held, each requester re-asserting after its `ack`.
  - Grant order is 0,1,2,3,0 under default build.
  - Grant order is 0,0,0… under `MEM_ARB_FIXED_PRIORITY_EN`.
- **Wrap and skip:** `rr_ptr`=3 and `req`=0101 gives grant to 0, then `rr_ptr`=1; next grant is 2.
- **LATENCY=0 write:** requester 2 writes 0x41 at address 0, offset 7.
  - `mem_mode`=01 and `mem_data`=0x41 for exactly one cycle.
  - `ack`=0100 the following cycle.
- **Withdrawal:** requester 1 drops `req` during WAIT; the operation completes and `ack`=0010 still pulses.
- **Reset:** `init_n` low during WAIT clears all outputs immediately. After release, `req`=0010 is granted with `rr_ptr` restarted at 0.
